regfile_wr_arbiter: RTL and testbench

- Owns the single write port of the 8x16 register file.
- Sequences a post-reset clear of all eight registers, since the register file itself has no reset.
- After the clear, arbitrates round-robin between two write requesters (ALU writeback = port 0, load unit = port 1) using a valid/ready handshake.
- Outputs drive the register file's wr_en / wr0_addr / wr0_data directly, registered.

---
 rtl/regfile_wr_arbiter.sv | 82 ++++++++
 tb/tb_regfile_wr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Write-port owner for the 8x16 register file: clears every register after reset,
// then round-robin arbitrates ALU writeback (port 0) and load unit (port 1).
module regfile_wr_arbiter #(
  parameter logic [15:0] INIT_VALUE    = 16'h0000,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [2:0]  req0_addr,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [2:0]  req1_addr,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        wr_en,
  output logic [2:0]  wr0_addr,
  output logic [15:0] wr0_data,
  output logic        init_done
);

  // state | meaning
  // INIT  | issuing clear writes to addresses 0..7, requesters held off
  // RUN   | round-robin arbitration, one write per accepted request
  typedef enum logic {INIT, RUN} state_t;

  localparam state_t RESET_STATE = INIT_ON_RESET ? INIT : RUN;

  state_t     state;
  logic [2:0] cnt;
  logic       rr_ptr;
  logic       run;

  assign run        = (state == RUN);
  assign req0_ready = run && req0_valid && (!rr_ptr || !req1_valid);
  assign req1_ready = run && req1_valid && ( rr_ptr || !req0_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RESET_STATE;
      cnt       <= 3'd0;
      rr_ptr    <= 1'b0;
      wr_en     <= 1'b0;
      wr0_addr  <= 3'd0;
      wr0_data  <= 16'h0000;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          wr_en    <= 1'b1;
          wr0_addr <= cnt;
          wr0_data <= INIT_VALUE;
          cnt      <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          init_done <= 1'b1;
          if (req0_ready) begin
            wr_en    <= 1'b1;
            wr0_addr <= req0_addr;
            wr0_data <= req0_data;
            rr_ptr   <= 1'b1;
          end else if (req1_ready) begin
            wr_en    <= 1'b1;
            wr0_addr <= req1_addr;
            wr0_data <= req1_data;
            rr_ptr   <= 1'b0;
          end else begin
            // address/data hold so the register file input stays quiet
            wr_en <= 1'b0;
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: two instances (clear-on-reset with A5A5, and no clear),
// directed scenarios with literal expectations plus randomized traffic against a model.
module tb_regfile_wr_arbiter;

  logic clk;
  logic rst_a, rst_b;
  logic        req_valid [2][2];
  logic [2:0]  req_addr  [2][2];
  logic [15:0] req_data  [2][2];

  logic        rdy0_a, rdy1_a, wr_en_a, init_done_a;
  logic [2:0]  wr0_addr_a;
  logic [15:0] wr0_data_a;
  logic        rdy0_b, rdy1_b, wr_en_b, init_done_b;
  logic [2:0]  wr0_addr_b;
  logic [15:0] wr0_data_b;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wr_arbiter #(.INIT_VALUE(16'hA5A5), .INIT_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst(rst_a),
    .req0_valid(req_valid[0][0]), .req0_addr(req_addr[0][0]), .req0_data(req_data[0][0]), .req0_ready(rdy0_a),
    .req1_valid(req_valid[0][1]), .req1_addr(req_addr[0][1]), .req1_data(req_data[0][1]), .req1_ready(rdy1_a),
    .wr_en(wr_en_a), .wr0_addr(wr0_addr_a), .wr0_data(wr0_data_a), .init_done(init_done_a));

  regfile_wr_arbiter #(.INIT_VALUE(16'h0000), .INIT_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst(rst_b),
    .req0_valid(req_valid[1][0]), .req0_addr(req_addr[1][0]), .req0_data(req_data[1][0]), .req0_ready(rdy0_b),
    .req1_valid(req_valid[1][1]), .req1_addr(req_addr[1][1]), .req1_data(req_data[1][1]), .req1_ready(rdy1_b),
    .wr_en(wr_en_b), .wr0_addr(wr0_addr_b), .wr0_data(wr0_data_b), .init_done(init_done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          n_edges [2];   // clock edges seen since reset released
  bit          prio    [2];   // port that wins when both are valid
  logic        e_wr_en [2];
  logic [2:0]  e_addr  [2];
  logic [15:0] e_data  [2];
  logic        e_done  [2];
  bit          granted [2][2];
  logic [15:0] m_rf    [2][8];
  logic [15:0] dut_rf  [2][8];

  function automatic bit clears(int i);
    return i == 0;
  endfunction

  function automatic logic [15:0] init_val(int i);
    return (i == 0) ? 16'hA5A5 : 16'h0000;
  endfunction

  function automatic bit exp_ready(int i, int p);
    bit live = !clears(i) || (n_edges[i] >= 8);
    return live && req_valid[i][p] && (int'(prio[i]) == p || !req_valid[i][1-p]);
  endfunction

  task automatic model_reset(int i);
    n_edges[i] = 0;
    prio[i]    = 1'b0;
    e_wr_en[i] = 1'b0;
    e_addr[i]  = 3'd0;
    e_data[i]  = 16'h0000;
    e_done[i]  = 1'b0;
    granted[i][0] = 1'b0;
    granted[i][1] = 1'b0;
  endtask

  task automatic model_edge(int i);
    int g;
    if (e_wr_en[i]) m_rf[i][e_addr[i]] = e_data[i];
    granted[i][0] = 1'b0;
    granted[i][1] = 1'b0;
    if (clears(i) && n_edges[i] < 8) begin
      e_wr_en[i] = 1'b1;
      e_addr[i]  = 3'(n_edges[i]);
      e_data[i]  = init_val(i);
      n_edges[i]++;
      if (n_edges[i] == 8) e_done[i] = 1'b1;
    end else begin
      e_done[i] = 1'b1;
      g = -1;
      if (req_valid[i][0] && req_valid[i][1]) g = int'(prio[i]);
      else if (req_valid[i][0]) g = 0;
      else if (req_valid[i][1]) g = 1;
      if (g >= 0) begin
        e_wr_en[i] = 1'b1;
        e_addr[i]  = req_addr[i][g];
        e_data[i]  = req_data[i][g];
        prio[i]    = (g == 0);
        granted[i][g] = 1'b1;
      end else begin
        e_wr_en[i] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) model_reset(0);
    else model_edge(0);
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) model_reset(1);
    else model_edge(1);
  end

  // register files attached to the DUT write ports
  always @(posedge clk) begin
    if (wr_en_a) dut_rf[0][wr0_addr_a] = wr0_data_a;
    if (wr_en_b) dut_rf[1][wr0_addr_b] = wr0_data_b;
  end

  // ---------------- per-cycle compare ----------------
  logic        a_rdy [2][2];
  logic        a_en  [2];
  logic        a_dn  [2];
  logic [2:0]  a_ad  [2];
  logic [15:0] a_dt  [2];

  always @(negedge clk) begin
    a_rdy[0][0] = rdy0_a; a_rdy[0][1] = rdy1_a; a_en[0] = wr_en_a; a_dn[0] = init_done_a;
    a_ad[0] = wr0_addr_a; a_dt[0] = wr0_data_a;
    a_rdy[1][0] = rdy0_b; a_rdy[1][1] = rdy1_b; a_en[1] = wr_en_b; a_dn[1] = init_done_b;
    a_ad[1] = wr0_addr_b; a_dt[1] = wr0_data_b;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_ready0", i), a_rdy[i][0], exp_ready(i, 0));
      chk($sformatf("m%0d_ready1", i), a_rdy[i][1], exp_ready(i, 1));
      chk($sformatf("m%0d_wr_en", i), a_en[i], e_wr_en[i]);
      chk($sformatf("m%0d_wr0_addr", i), a_ad[i], e_addr[i]);
      chk($sformatf("m%0d_wr0_data", i), a_dt[i], e_data[i]);
      chk($sformatf("m%0d_init_done", i), a_dn[i], e_done[i]);
      for (int r = 0; r < 8; r++)
        chk($sformatf("m%0d_rf%0d", i, r), dut_rf[i][r], m_rf[i][r]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(int i, int p, logic v, logic [2:0] a, logic [15:0] d);
    req_valid[i][p] = v;
    req_addr[i][p]  = a;
    req_data[i][p]  = d;
  endtask

  task automatic drive_random;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++)
        if (!req_valid[i][p] || granted[i][p])
          set_req(i, p, ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 16'($urandom));
    rst_a = ($urandom_range(0, 299) == 0);
    rst_b = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) set_req(i, p, 1'b0, 3'd0, 16'h0000);
    step; step;
    chk("rst_wr_en", wr_en_a, 0);
    chk("rst_wr0_addr", wr0_addr_a, 0);
    chk("rst_wr0_data", wr0_data_a, 0);
    chk("rst_init_done", init_done_a, 0);

    // clear sequence with a request waiting throughout INIT
    rst_a = 1'b0;
    set_req(0, 0, 1'b1, 3'd6, 16'h6666);
    for (int k = 1; k <= 8; k++) begin
      step;
      chk("clr_wr_en", wr_en_a, 1);
      chk("clr_addr", wr0_addr_a, k - 1);
      chk("clr_data", wr0_data_a, 16'hA5A5);
      chk("clr_done", init_done_a, (k == 8));
      chk("clr_ready0", rdy0_a, (k == 8));
    end
    step;
    chk("first_grant_addr", wr0_addr_a, 6);
    chk("first_grant_data", wr0_data_a, 16'h6666);
    set_req(0, 0, 1'b0, 3'd0, 16'h0000);
    for (int r = 0; r < 8; r++) chk($sformatf("clr_rf%0d", r), dut_rf[0][r], 16'hA5A5);
    step;
    chk("idle_wr_en", wr_en_a, 0);
    chk("rf6", dut_rf[0][6], 16'h6666);

    // single requester
    set_req(0, 0, 1'b1, 3'd3, 16'h1234);
    #1 chk("single_ready0", rdy0_a, 1);
    chk("single_ready1", rdy1_a, 0);
    step;
    chk("single_wr_en", wr_en_a, 1);
    chk("single_addr", wr0_addr_a, 3);
    chk("single_data", wr0_data_a, 16'h1234);
    set_req(0, 0, 1'b0, 3'd0, 16'h0000);
    step;
    chk("single_after", wr_en_a, 0);

    // same address, port 1 has priority
    set_req(0, 0, 1'b1, 3'd5, 16'hAAAA);
    set_req(0, 1, 1'b1, 3'd5, 16'h5555);
    #1 chk("same_ready1", rdy1_a, 1);
    chk("same_ready0", rdy0_a, 0);
    step;
    chk("same_first", wr0_data_a, 16'h5555);
    set_req(0, 1, 1'b0, 3'd0, 16'h0000);
    #1 chk("same_ready0b", rdy0_a, 1);
    step;
    chk("same_second", wr0_data_a, 16'hAAAA);
    set_req(0, 0, 1'b0, 3'd0, 16'h0000);
    step; step;
    chk("same_rf5", dut_rf[0][5], 16'hAAAA);

    // hand priority back to port 0, then contention
    set_req(0, 1, 1'b1, 3'd0, 16'h0000);
    step;
    set_req(0, 1, 1'b0, 3'd0, 16'h0000);
    set_req(0, 0, 1'b1, 3'd1, 16'h0001);
    set_req(0, 1, 1'b1, 3'd2, 16'h0002);
    for (int j = 0; j < 4; j++) begin
      #1 chk("cont_ready0", rdy0_a, (j % 2 == 0));
      chk("cont_ready1", rdy1_a, (j % 2 == 1));
      step;
      chk("cont_addr", wr0_addr_a, (j % 2 == 0) ? 1 : 2);
    end
    set_req(0, 0, 1'b0, 3'd0, 16'h0000);
    set_req(0, 1, 1'b0, 3'd0, 16'h0000);

    // reset during a RUN grant; pending request must not be issued by the reset
    set_req(0, 0, 1'b1, 3'd4, 16'h4444);
    #1 chk("rr_ready0", rdy0_a, 1);
    rst_a = 1'b1;
    #1 chk("rr_wr_en", wr_en_a, 0);
    chk("rr_done", init_done_a, 0);
    chk("rr_ready0_low", rdy0_a, 0);
    step;
    rst_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step;
      chk("rr_clr_addr", wr0_addr_a, k - 1);
    end
    // reset mid-INIT with cnt = 4
    rst_a = 1'b1;
    #1 chk("ri_wr_en", wr_en_a, 0);
    chk("ri_done", init_done_a, 0);
    step;
    rst_a = 1'b0;
    step;
    chk("ri_restart_addr", wr0_addr_a, 0);
    chk("ri_restart_en", wr_en_a, 1);
    repeat (7) step;
    chk("ri_done_again", init_done_a, 1);
    step;
    chk("ri_pending_addr", wr0_addr_a, 4);
    chk("ri_pending_data", wr0_data_a, 16'h4444);
    set_req(0, 0, 1'b0, 3'd0, 16'h0000);

    // instance without clear
    set_req(1, 1, 1'b1, 3'd7, 16'hBEEF);
    rst_b = 1'b0;
    step;
    chk("nc_done", init_done_b, 1);
    chk("nc_wr_en", wr_en_b, 1);
    chk("nc_addr", wr0_addr_b, 7);
    chk("nc_data", wr0_data_b, 16'hBEEF);
    set_req(1, 1, 1'b0, 3'd0, 16'h0000);
    step;
    chk("nc_idle", wr_en_b, 0);

    // randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      step;
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
